vga_pixel_pipeline: RTL and testbench
=====================================

# vga_pixel_pipeline

Downstream stage of the VGA timing generator. It consumes the timing generator's sync, active and x/y outputs and fetches 4-bpp pixel bytes from a synchronous-read framebuffer RAM. It maps each nibble through a CPU-writable 16-entry palette and drives registered RGB plus sync outputs, all aligned to the same pixel. It also owns the resolution mode: the mode is latched once per frame and fed back to the timing generator.

## Interface
Parameters:
- FB_AW, 18: framebuffer byte-address width.
- FB_BASE, 0: byte address of pixel (0,0).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- pixel_strobe, in, 1: pixel enable, same strobe the timing generator uses.
- hsync_in, vsync_in, in, 1 each: active-low syncs from the timing generator.
- active_in, in, 1: active-video flag from the timing generator.
- x, in, 10: column from the timing generator, already shifted by mode.
- y, in, 9: row from the timing generator, already shifted by mode.
- mode_req, in, 1: requested mode; 0 = 640x480, 1 = 320x240.
- mode_out, out, 1: latched mode; drives the timing generator's mode input.
- fb_addr, out, FB_AW: framebuffer read address.
- fb_rd_en, out, 1: framebuffer read enable.
- fb_rdata, in, 8: read data, valid exactly one clk after fb_rd_en.
- pal_we, in, 1: palette write strobe.
- pal_addr, in, 4: palette write index.
- pal_wdata, in, 12: palette write data {r,g,b}.
- vga_r, vga_g, vga_b, out, 4 each: pixel colour.
- vga_hsync, vga_vsync, out, 1 each: delayed syncs, active-low.
- frame_start, out, 1: one-clk pulse at the latch point.

## Operation
- Pipeline advances only on cycles with pixel_strobe=1. Registers hold otherwise, except the palette write port and fb_rdata capture.
- **S0, address stage.** On strobe with active_in=1:
  - fb_addr = FB_BASE + y*stride + (x>>1).
  - stride = 320 when mode_out=0, 160 when mode_out=1.
  - Multiply as shift-add: 320 = (y<<8)+(y<<6); 160 = (y<<7)+(y<<5).
  - Result truncated to FB_AW bits.
  - fb_rd_en=1 for that single clk.
  - active_in=0: fb_rd_en=0, fb_addr holds its last value.
- **S1, data stage.**
  - fb_rdata is captured into a byte register on the clk after fb_rd_en.
  - This capture does not wait for a strobe.
  - On the next strobe the byte register is sampled into the S1 data register.
  - x[0] and active are piped alongside the data.
- **S2, colour stage.**
  - Nibble select: even x → fb byte [3:0]; odd x → [7:4].
  - rgb = palette[nibble] when the piped active=1, else 12'h000.
- hsync_in and vsync_in pass through a 3-strobe delay line so that vga_hsync, vga_vsync and rgb all describe the same pixel.
- **Palette.**
  - 16×12 register file; a write occurs on any clk with pal_we=1, independent of strobe.
  - A write to the entry being read in the same clk: S2 gets the old value, and the new value is visible from the next clk.
- **Mode latch.**
  - mode_out <= mode_req on the strobe where vsync_in is 1 in the previous strobe and 0 now (start of the vsync pulse).
  - frame_start=1 for that clk.
  - Mode never changes mid-frame.

## Timing
- Latency from timing-generator inputs to VGA outputs: 3 strobes.
- fb_rdata is needed exactly 1 clk after fb_rd_en. Requirement: pixel_strobe period ≥ 2 clk.
- Reset values:
  - vga_hsync=1, vga_vsync=1, sync delay lines all 1.
  - rgb=0, fb_rd_en=0, fb_addr=0, frame_start=0, mode_out=0.
  - Palette entry i = {i,i,i} (grey ramp).
  - Previous-vsync register=1.
- Reset asserted mid-line: every output takes its reset value on the next clk, and pipeline contents are discarded.
- Reset has priority over a simultaneous pal_we.
- The last active pixel of a line is flushed normally. Blanking pixels that enter after it produce rgb=0.

## Structure
- Shared video package:
  - Mode encoding constants.
  - Strides 320 and 160.
  - Pipeline depth 3.
  - rgb12 typedef.
  - Reset palette function.
- One natural sub-module: vga_palette (16×12 register file with one write port and one registered read port).

## Test plan
- Reset, then strobe every 4 clk with active_in=0 → rgb=0, vga_hsync=vga_vsync=1, fb_rd_en never asserted.
- mode_out=0, y=2, x=5, FB_BASE=0 → fb_addr=642. fb_rdata=8'hA3 with default palette → 3 strobes later rgb={A,A,A}; with x=4 → {3,3,3}.
- mode_req=1, vsync_in falls → frame_start pulses once, mode_out=1. Then y=2, x=5 → fb_addr=322.
- mode_req toggled mid-frame → mode_out unchanged until the next vsync fall.
- pal_we, pal_addr=3, pal_wdata=12'hF00 on the same clk as the S2 lookup of index 3 → that pixel shows 333, and the next index-3 pixel shows F00.
- hsync_in pulse low for 96 strobes → vga_hsync low for 96 strobes, starting exactly 3 strobes later.
- Reset mid-line → outputs at reset values next clk. Palette returns to the grey ramp.

Source files
------------

// File: rtl/vga_pixel_pipeline_pkg.sv
// Shared video definitions for the VGA pixel pipeline: mode encoding, strides,
// pipeline depth, the 12-bit colour type and the reset palette.
package vga_pixel_pipeline_pkg;

  localparam logic MODE_640X480 = 1'b0;
  localparam logic MODE_320X240 = 1'b1;

  localparam int STRIDE_640 = 320;
  localparam int STRIDE_320 = 160;

  localparam int PIPE_DEPTH  = 3;
  localparam int PAL_ENTRIES = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Grey ramp: entry i is {i,i,i}.
  function automatic rgb12_t reset_palette_entry(input logic [3:0] idx);
    rgb12_t c;
    c.r = idx;
    c.g = idx;
    c.b = idx;
    return c;
  endfunction

  // Byte offset of a framebuffer row, built from shifts so no multiplier is needed.
  function automatic logic [31:0] row_offset(input logic [8:0] y, input logic mode);
    logic [31:0] yw;
    yw = 32'(y);
    if (mode == MODE_320X240) return (yw << 7) + (yw << 5);
    return (yw << 8) + (yw << 6);
  endfunction

endpackage

// File: rtl/vga_pixel_pipeline_palette.sv
// 16x12 colour palette: one CPU write port and one registered, strobe-enabled
// read port whose output is forced to black for blanking pixels.
module vga_palette
  import vga_pixel_pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  rgb12_t       wdata,
  input  logic         rd_en,
  input  logic         rd_valid,
  input  logic [3:0]   raddr,
  output rgb12_t       rd_data
);

  rgb12_t mem [PAL_ENTRIES];

  // NOTE: this array is deliberately reset -- the grey ramp must be visible
  // straight out of reset, and 16 entries are cheap enough as flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAL_ENTRIES; i++) mem[i] <= reset_palette_entry(4'(i));
      rd_data <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      // A same-clk write to raddr is not seen here; the read takes the old entry.
      if (rd_en) rd_data <= rd_valid ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Three-strobe pixel pipeline behind the VGA timing generator: framebuffer
// address generation, byte fetch, palette lookup, sync alignment and mode latch.
module vga_pixel_pipeline
  import vga_pixel_pipeline_pkg::*;
#(
  parameter int          FB_AW   = 18,
  parameter int unsigned FB_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_strobe,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             active_in,
  input  logic [9:0]       x,
  input  logic [8:0]       y,
  input  logic             mode_req,
  output logic             mode_out,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_rd_en,
  input  logic [7:0]       fb_rdata,
  input  logic             pal_we,
  input  logic [3:0]       pal_addr,
  input  logic [11:0]      pal_wdata,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             frame_start
);

  logic [FB_AW-1:0] addr_next;
  logic             s0_active, s0_xlsb;
  logic             rd_pending;
  logic [7:0]       byte_q;
  logic [7:0]       s1_data;
  logic             s1_active, s1_xlsb;
  logic [3:0]       s1_nibble;
  logic [PIPE_DEPTH-1:0] hsync_dly, vsync_dly;
  logic             prev_vsync;
  rgb12_t           pal_rgb;

  assign addr_next = FB_AW'(FB_BASE + row_offset(y, mode_out) + 32'(x[9:1]));

  // S0: address stage. fb_rd_en is a single-clk pulse per active strobe.
  // NOTE: all state uses non-blocking assignments; the default-then-override
  // pattern below relies on the last <= in the block winning.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_addr   <= '0;
      fb_rd_en  <= 1'b0;
      s0_active <= 1'b0;
      s0_xlsb   <= 1'b0;
    end else begin
      fb_rd_en <= 1'b0;
      if (pixel_strobe) begin
        s0_active <= active_in;
        s0_xlsb   <= x[0];
        if (active_in) begin
          fb_addr  <= addr_next;
          fb_rd_en <= 1'b1;
        end
      end
    end
  end

  // S1: data stage. Read data arrives one clk after fb_rd_en; at the minimum
  // strobe period that is the same clk as the next strobe, hence the bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      byte_q     <= '0;
      s1_data    <= '0;
      s1_active  <= 1'b0;
      s1_xlsb    <= 1'b0;
    end else begin
      rd_pending <= fb_rd_en;
      if (rd_pending) byte_q <= fb_rdata;
      if (pixel_strobe) begin
        s1_data   <= rd_pending ? fb_rdata : byte_q;
        s1_active <= s0_active;
        s1_xlsb   <= s0_xlsb;
      end
    end
  end

  assign s1_nibble = s1_xlsb ? s1_data[7:4] : s1_data[3:0];

  // S2: colour stage lives in the palette's registered read port.
  vga_palette u_palette (
    .clk      (clk),
    .reset    (reset),
    .we       (pal_we),
    .waddr    (pal_addr),
    .wdata    (rgb12_t'(pal_wdata)),
    .rd_en    (pixel_strobe),
    .rd_valid (s1_active),
    .raddr    (s1_nibble),
    .rd_data  (pal_rgb)
  );

  assign vga_r = pal_rgb.r;
  assign vga_g = pal_rgb.g;
  assign vga_b = pal_rgb.b;

  // Sync delay lines match the three pipeline stages so syncs and colour align.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_dly <= '1;
      vsync_dly <= '1;
    end else if (pixel_strobe) begin
      hsync_dly <= {hsync_dly[PIPE_DEPTH-2:0], hsync_in};
      vsync_dly <= {vsync_dly[PIPE_DEPTH-2:0], vsync_in};
    end
  end

  assign vga_hsync = hsync_dly[PIPE_DEPTH-1];
  assign vga_vsync = vsync_dly[PIPE_DEPTH-1];

  // Mode is only taken at the start of the vsync pulse, never mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vsync  <= 1'b1;
      mode_out    <= MODE_640X480;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pixel_strobe) begin
        prev_vsync <= vsync_in;
        if (prev_vsync && !vsync_in) begin
          mode_out    <= mode_req;
          frame_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed scoreboard bench for vga_pixel_pipeline with a registered-read
// framebuffer model and an independent palette/mode reference.
module tb_vga_pixel_pipeline;
  import vga_pixel_pipeline_pkg::*;

  localparam int FB_AW   = 18;
  localparam int FB_BASE = 0;

  logic             clk = 1'b0;
  logic             reset;
  logic             pixel_strobe;
  logic             hsync_in, vsync_in, active_in;
  logic [9:0]       x;
  logic [8:0]       y;
  logic             mode_req, mode_out;
  logic [FB_AW-1:0] fb_addr;
  logic             fb_rd_en;
  logic [7:0]       fb_rdata = 8'h00;
  logic             pal_we;
  logic [3:0]       pal_addr;
  logic [11:0]      pal_wdata;
  logic [3:0]       vga_r, vga_g, vga_b;
  logic             vga_hsync, vga_vsync, frame_start;

  vga_pixel_pipeline #(.FB_AW(FB_AW), .FB_BASE(FB_BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_strobe (pixel_strobe),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .active_in    (active_in),
    .x            (x),
    .y            (y),
    .mode_req     (mode_req),
    .mode_out     (mode_out),
    .fb_addr      (fb_addr),
    .fb_rd_en     (fb_rd_en),
    .fb_rdata     (fb_rdata),
    .pal_we       (pal_we),
    .pal_addr     (pal_addr),
    .pal_wdata    (pal_wdata),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [FB_AW-1:0] a);
    if (a == FB_AW'(642)) return 8'hA3;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) if (fb_rd_en) fb_rdata <= ram_byte(fb_addr);

  typedef struct packed {
    logic       active;
    logic [3:0] idx;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] pal_model [16];
  logic        mode_model, prev_vs_model;
  logic [11:0] last_rgb;
  logic        last_hs, last_vs;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic strobe_during, input logic pal_we_during);
    reset        = 1'b1;
    pixel_strobe = strobe_during;
    pal_we       = pal_we_during;
    pal_addr     = 4'd3;
    pal_wdata    = 12'hFFF;
    @(posedge clk); #1;
    pixel_strobe = 1'b0;
    pal_we       = 1'b0;
    check("rst_rgb",   {vga_r, vga_g, vga_b}, 12'h000);
    check("rst_hsync", vga_hsync, 1'b1);
    check("rst_vsync", vga_vsync, 1'b1);
    check("rst_rd_en", fb_rd_en, 1'b0);
    check("rst_addr",  fb_addr, '0);
    check("rst_fs",    frame_start, 1'b0);
    check("rst_mode",  mode_out, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) pal_model[i] = {4'(i), 4'(i), 4'(i)};
    sb.delete();
    repeat (2) sb.push_back('{active: 1'b0, idx: 4'd0, hs: 1'b1, vs: 1'b1});
    mode_model    = 1'b0;
    prev_vs_model = 1'b1;
    last_rgb      = 12'h000;
    last_hs       = 1'b1;
    last_vs       = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    check("rd_en_idle", fb_rd_en, 1'b0);
    check("fs_idle",    frame_start, 1'b0);
    check("rgb_hold",   {vga_r, vga_g, vga_b}, last_rgb);
    check("hs_hold",    vga_hsync, last_hs);
    check("vs_hold",    vga_vsync, last_vs);
  endtask

  // One strobe carrying a pixel, optionally with a palette write on the same clk,
  // followed by `gap` strobe-free clks.
  task automatic strobe_px(input logic act, input int xx, input int yy, input logic hs,
                           input logic vs, input logic we, input logic [3:0] wa,
                           input logic [11:0] wd, input int gap);
    exp_t             e, f;
    logic [FB_AW-1:0] a;
    logic [7:0]       b;
    logic [11:0]      exp_rgb;
    logic             exp_fs;
    a = FB_AW'(FB_BASE + yy * (mode_model ? STRIDE_320 : STRIDE_640) + xx / 2);
    b = ram_byte(a);
    x = 10'(xx); y = 9'(yy); active_in = act; hsync_in = hs; vsync_in = vs;
    pal_we = we; pal_addr = wa; pal_wdata = wd;
    pixel_strobe = 1'b1;
    e.active = act;
    e.idx    = ((xx & 1) == 1) ? b[7:4] : b[3:0];
    e.hs     = hs;
    e.vs     = vs;
    sb.push_back(e);
    f       = sb.pop_front();
    exp_rgb = f.active ? pal_model[f.idx] : 12'h000;
    exp_fs  = prev_vs_model && !vs;
    @(posedge clk);
    if (we) pal_model[wa] = wd;
    if (exp_fs) mode_model = mode_req;
    prev_vs_model = vs;
    #1;
    pixel_strobe = 1'b0;
    pal_we       = 1'b0;
    check("rgb",   {vga_r, vga_g, vga_b}, exp_rgb);
    check("hsync", vga_hsync, f.hs);
    check("vsync", vga_vsync, f.vs);
    check("rd_en", fb_rd_en, act);
    if (act) check("fb_addr", fb_addr, a);
    check("frame_start", frame_start, exp_fs);
    check("mode_out", mode_out, mode_model);
    last_rgb = exp_rgb;
    last_hs  = f.hs;
    last_vs  = f.vs;
    for (int i = 0; i < gap; i++) idle();
  endtask

  initial begin
    reset = 1'b0; pixel_strobe = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    active_in = 1'b0; x = '0; y = '0; mode_req = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    // Blanking only: black, syncs high, no reads.
    for (int i = 0; i < 6; i++) strobe_px(1'b0, i, 0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    // Row 2 at 640x480: x=4 -> 333, x=5 -> AAA (byte A3 at 642), then minimum strobe period.
    for (int xx = 4; xx < 10; xx++) strobe_px(1'b1, xx, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    for (int xx = 10; xx < 14; xx++) strobe_px(1'b1, xx, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 1);
    for (int i = 0; i < 3; i++) strobe_px(1'b0, 0, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    // Switch to 320x240 at a vsync fall; row 2 then starts at byte 320.
    mode_req = 1'b1;
    strobe_px(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    for (int xx = 4; xx < 8; xx++) strobe_px(1'b1, xx, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    // Mode request changes mid-frame must not take effect until the next vsync fall.
    mode_req = 1'b0;
    for (int xx = 8; xx < 12; xx++) strobe_px(1'b1, xx, 3, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    mode_req = 1'b1;
    strobe_px(1'b1, 12, 3, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    mode_req = 1'b0;
    strobe_px(1'b0, 0, 3, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    // Palette write colliding with the S2 lookup of index 3.
    strobe_px(1'b1, 4, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b1, 6, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b1, 7, 2, 1'b1, 1'b1, 1'b1, 4'd3, 12'hF00, 3);
    strobe_px(1'b1, 4, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b1, 5, 2, 1'b1, 1'b1, 1'b1, 4'd10, 12'h0F0, 3);
    for (int i = 0; i < 3; i++) strobe_px(1'b0, 0, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b1, 5, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    for (int i = 0; i < 3; i++) strobe_px(1'b0, 0, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    // 96-strobe hsync pulse must come out 96 strobes wide, 3 strobes later.
    for (int i = 0; i < 96; i++) strobe_px(1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    for (int i = 0; i < 4; i++) strobe_px(1'b0, 0, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    // Reset mid-line with a strobe and a palette write pending; grey ramp must return.
    for (int xx = 0; xx < 5; xx++) strobe_px(1'b1, xx, 1, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    do_reset(1'b1, 1'b1);
    strobe_px(1'b1, 4, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    strobe_px(1'b1, 5, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);
    for (int i = 0; i < 3; i++) strobe_px(1'b0, 0, 2, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
